// File: rtl/dec_scan_seq.sv
// dec_scan_seq: select sequencer that drives the 2-bit code i[1:0] of a 2x4
// decoder. Steps the code every DIV enabled cycles, up or down, either
// continuously or as a single sweep, with load and stop control.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             tick enable (0 freezes prescaler and sel)
//   start          begin scanning (IDLE only)
//   stop           abort scanning (SCAN only)
//   mode           0 = continuous, 1 = single sweep (latched on start)
//   dir            0 = up, 1 = down (sampled at each tick)
//   load, load_val jam sel to load_val / start value with start
//   sel            registered code to the decoder
//   sel_vld        sel is an active scan code
//   busy           sequencer is scanning
//   done           one-cycle pulse at sweep end or at each wrap
//   y_ref          one-hot golden reference of sel (DEC_SCAN_ONEHOT_EN only)
//
// Optional feature macro: DEC_SCAN_ONEHOT_EN
module dec_scan_seq #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic       dir,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] sel,
  output logic       sel_vld,
  output logic       busy,
`ifdef DEC_SCAN_ONEHOT_EN
  output logic [3:0] y_ref,
`endif
  output logic       done
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      sel_q, sel_d;
  logic            sel_vld_q, sel_vld_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            mode_q, mode_d;
  logic            tick_c;
  logic            at_end_c;

  // Step strobe and end-of-range detect for the current direction.
  assign tick_c   = (state_q == SCAN) && en && (presc_q == PW'(DIV - 1));
  assign at_end_c = dir ? (sel_q == 2'b00) : (sel_q == 2'b11);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop beats load beats tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SCAN;
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!load && tick_c && at_end_c && mode_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values for the registered outputs.
  always_comb begin
    sel_d   = sel_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = load ? load_val : (dir ? 2'b11 : 2'b00);
          presc_d = '0;
          mode_d  = mode;
        end
      end
      SCAN: begin
        if (stop) begin
          sel_d = sel_q;
        end else if (load) begin
          sel_d   = load_val;
          presc_d = '0;
        end else if (en) begin
          if (tick_c) begin
            presc_d = '0;
            done_d  = at_end_c;
            // A single sweep parks on its end value; otherwise mod-4 step wraps.
            if (!(at_end_c && mode_q)) begin
              sel_d = dir ? (sel_q - 2'd1) : (sel_q + 2'd1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      default: begin
        sel_d = sel_q;
      end
    endcase
    sel_vld_d = (state_d == SCAN);
    busy_d    = (state_d == SCAN);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 2'b00;
      presc_q   <= '0;
      mode_q    <= 1'b0;
      sel_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      sel_vld_q <= sel_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sel     = sel_q;
  assign sel_vld = sel_vld_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef DEC_SCAN_ONEHOT_EN
  logic [3:0] y_ref_q, y_ref_d;

  // One-hot reference, computed from the next sel so it lines up with sel.
  always_comb begin
    y_ref_d = sel_vld_d ? (4'b0001 << sel_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_ref_q <= 4'b0000;
    end else begin
      y_ref_q <= y_ref_d;
    end
  end

  assign y_ref = y_ref_q;
`endif

endmodule

// File: tb/tb_dec_scan_seq.sv
// Testbench for dec_scan_seq: directed scenarios plus random stimulus,
// checked against a cycle-level behavioural model.
module tb_dec_scan_seq;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, start, stop, mode, dir, load;
  logic [1:0] load_val;
  logic [1:0] sel;
  logic       sel_vld, busy, done;
`ifdef DEC_SCAN_ONEHOT_EN
  logic [3:0] y_ref;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  // Behavioural model state.
  bit m_scan;
  int m_sel;
  int m_cnt;
  bit m_mode;
  bit m_done;

  always #5 clk = ~clk;

  dec_scan_seq #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
    .mode(mode), .dir(dir), .load(load), .load_val(load_val),
    .sel(sel), .sel_vld(sel_vld), .busy(busy),
`ifdef DEC_SCAN_ONEHOT_EN
    .y_ref(y_ref),
`endif
    .done(done)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_sel = 0; m_cnt = 0; m_mode = 0; m_done = 0;
  endtask

  // One clock of the spec's rules, using the inputs present at the edge.
  task automatic model_clock();
    int last;
    m_done = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_scan) begin
      if (start) begin
        m_scan = 1;
        m_sel  = load ? int'(load_val) : (dir ? 3 : 0);
        m_cnt  = 0;
        m_mode = mode;
      end
    end else if (stop) begin
      m_scan = 0;
    end else if (load) begin
      m_sel = int'(load_val);
      m_cnt = 0;
    end else if (en) begin
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        last  = dir ? 0 : 3;
        if (m_sel == last) begin
          m_done = 1;
          if (m_mode) m_scan = 0;
          else        m_sel  = dir ? 3 : 0;
        end else begin
          m_sel = dir ? m_sel - 1 : m_sel + 1;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".sel"},     4'(sel),     4'(m_sel));
    chk({tag, ".sel_vld"}, 4'(sel_vld), 4'(m_scan));
    chk({tag, ".busy"},    4'(busy),    4'(m_scan));
    chk({tag, ".done"},    4'(done),    4'(m_done));
`ifdef DEC_SCAN_ONEHOT_EN
    chk({tag, ".y_ref"}, y_ref, m_scan ? (4'b0001 << m_sel) : 4'b0000);
`endif
  endtask

  // Advance one clock, update the model, check 1 time unit after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    en = 1; start = 0; stop = 0; mode = 0; dir = 0; load = 0; load_val = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_model("reset");
    rst_n = 1'b1;
    step("idle");

    // Continuous up: each code held DIV cycles, done coincident with 3->0.
    start = 1; mode = 0; dir = 0;
    step("cont_start");
    start = 0;
    for (int k = 1; k <= 4 * DIV; k++) begin
      step("cont");
      chk("cont_seq", 4'(sel), 4'((k / DIV) % 4));
      chk("cont_done", 4'(done), 4'(k == 4 * DIV));
    end
    stop = 1;
    step("cont_stop");
    stop = 0;

    // Single sweep down: 3,2,1,0 then done with busy/sel_vld low, sel parked.
    start = 1; mode = 1; dir = 1;
    step("sweep_start");
    start = 0;
    for (int k = 1; k < 4 * DIV; k++) begin
      step("sweep");
      chk("sweep_seq", 4'(sel), 4'(3 - k / DIV));
    end
    step("sweep_end");
    chk("sweep_done", {1'b0, done, busy, sel_vld}, 4'b0100);
    chk("sweep_park", 4'(sel), 4'd0);
    step("sweep_after");
    chk("sweep_done_1cyc", 4'(done), 4'd0);

    // Load then stop+load priority.
    start = 1; mode = 0; dir = 0;
    step("ld_start");
    start = 0;
    while (m_sel != 1) step("ld_run");
    load = 1; load_val = 2'd3;
    step("ld_load");
    chk("ld_sel", 4'(sel), 4'd3);
    load = 0;
    for (int k = 0; k < DIV; k++) step("ld_hold");
    chk("ld_wrap", {2'b00, sel}, 4'd0);
    step("ld_run2");
    stop = 1; load = 1; load_val = 2'd2;
    step("stop_load");
    chk("stop_load_sel", {busy, sel_vld, sel}, 4'b0000);
    stop = 0; load = 0;
    step("stop_idle");

    // en gating: toggling en doubles the hold time, sel_vld stays high.
    start = 1; mode = 0; dir = 0;
    step("en_start");
    start = 0;
    for (int k = 1; k <= 4 * DIV * 2; k++) begin
      en = ~en;
      step("en");
      chk("en_vld", 4'(sel_vld), 4'd1);
    end
    en = 1;

    // Reset mid-scan, asserted between edges.
    while (m_sel != 2) step("rst_run");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async", {busy, sel_vld, sel}, 4'b0000);
    step("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step("rst_after");

    // Random stimulus against the model.
    for (int k = 0; k < 800; k++) begin
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 23) == 0);
      load_val = 2'($urandom_range(0, 3));
      mode     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      en       = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
